// File: rtl/strobe_pkg.sv
// strobe_pkg: shared state encoding and tick/width helpers for the strobe generator and meter
package strobe_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, MEASURE = 2'd2} state_t;
  function automatic int ns_to_ticks(input longint ns, input longint hz);
    return int'((ns * hz + 64'd999_999_999) / 64'd1_000_000_000);
  endfunction
  function automatic int cnt_width(input int max_ticks);
    return $clog2(max_ticks + 1);
  endfunction
endpackage

// File: rtl/strobe_edge_detector.sv
// strobe_edge_detector: rising-edge pulse of a strobe; STROBE_SYNC_EN adds a two-flop synchronizer
module strobe_edge_detector (
  input  logic Clock,
  input  logic Reset,
  input  logic strobe,
  output logic rise
);
  logic s;
  logic strobe_q;
`ifdef STROBE_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge Clock)
    if (Reset) sync <= 2'b11;
    else sync <= {sync[0], strobe};
  assign s = sync[1];
`else
  assign s = strobe;
`endif
  // history resets high so a strobe already high at reset release is not an edge
  always_ff @(posedge Clock)
    if (Reset) strobe_q <= 1'b1;
    else strobe_q <= s;
  assign rise = s & ~strobe_q;
endmodule

// File: rtl/strobe_period_meter.sv
// strobe_period_meter: measures ticks between strobe rising edges, range check and timeout; STROBE_SYNC_EN optional
module strobe_period_meter import strobe_pkg::*; #(
  parameter int CLOCK_HZ = 10_000_000,
  parameter int MAX_PERIOD_NS = 1_000_000,
  parameter int EXPECTED_TICKS = 11,
  parameter int TOLERANCE_TICKS = 1,
  localparam int MAX_TICKS = ns_to_ticks(MAX_PERIOD_NS, CLOCK_HZ),
  localparam int WIDTH = cnt_width(MAX_TICKS)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable_i,
  input  logic             Strobe_i,
  output logic [WIDTH-1:0] Period_o,
  output logic             Valid_o,
  output logic             InRange_o,
  output logic             Timeout_o,
  output logic             Busy_o
);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_TICKS);
  localparam logic signed [WIDTH:0] EXP_S = (WIDTH+1)'(EXPECTED_TICKS);
  localparam logic signed [WIDTH:0] TOL_S = (WIDTH+1)'(TOLERANCE_TICKS);
  state_t state;
  logic [WIDTH-1:0] cnt;
  logic rise;
  logic signed [WIDTH:0] diff;
  logic in_range;
  strobe_edge_detector u_edge (.Clock(Clock), .Reset(Reset), .strobe(Strobe_i), .rise(rise));
  // one extra bit keeps the signed difference exact for every counter value
  assign diff = $signed({1'b0, cnt}) - EXP_S;
  assign in_range = (diff >= -TOL_S) && (diff <= TOL_S);
  assign Busy_o = state == MEASURE;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      Period_o <= '0;
      InRange_o <= 1'b0;
      Valid_o <= 1'b0;
      Timeout_o <= 1'b0;
    end else begin
      Valid_o <= 1'b0;
      Timeout_o <= 1'b0;
      if (!Enable_i) begin
        state <= IDLE;
        cnt <= '0;
      end else if (state == IDLE) begin
        state <= ARMED;
      end else if (state == ARMED) begin
        if (rise) begin
          cnt <= WIDTH'(1);
          state <= MEASURE;
        end
      end else if (rise) begin
        Period_o <= cnt;
        InRange_o <= in_range;
        Valid_o <= 1'b1;
        cnt <= WIDTH'(1);
      end else if (cnt == MAX_CNT) begin
        Timeout_o <= 1'b1;
        cnt <= '0;
        state <= ARMED;
      end else begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end
endmodule
